// File: rtl/if_id_pipe_reg_pkg.sv
// rtl/if_id_pipe_reg_pkg.sv - shared pipeline constants for the inter-stage registers
package if_id_pipe_reg_pkg;

  localparam int PIPE_DATA_W = 32;
  // sll $0,$0,0 encodes as all zeros and is the canonical bubble
  localparam logic [PIPE_DATA_W-1:0] PIPE_NOP_INSTR = 32'h0000_0000;
  localparam int PIPE_CNT_W = 16;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic valid/ready main+skid register with synchronous clear
module pipe_skid_buf #(
  parameter int          W       = 64,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] in_tdata,
  input  logic         in_tvalid,
  output logic         in_tready,
  output logic [W-1:0] out_tdata,
  output logic         out_tvalid,
  input  logic         out_tready
);

  logic         m_valid_q, m_valid_d;
  logic [W-1:0] m_data_q, m_data_d;
  logic         s_valid_q, s_valid_d;
  logic [W-1:0] s_data_q, s_data_d;

  // Ready depends only on registered state, so no id_ready -> if_ready path
  assign in_tready  = !s_valid_q;
  assign out_tvalid = m_valid_q;
  assign out_tdata  = m_data_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (clr) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_data_d  = RST_VAL;
    end else if (!m_valid_q || out_tready) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (in_tvalid) begin
        m_valid_d = 1'b1;
        m_data_d  = in_tdata;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_tvalid && in_tready) begin
      // Main is stalled: park the in-flight beat in the skid slot
      s_valid_d = 1'b1;
      s_data_d  = in_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= RST_VAL;
      s_data_q  <= RST_VAL;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - IF/ID pipeline register with skid buffer, flush and stall counter
module if_id_pipe_reg
  import if_id_pipe_reg_pkg::*;
#(
  parameter int                DATA_W    = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = PIPE_NOP_INSTR,
  parameter int                CNT_W     = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [DATA_W-1:0] if_pc4,
  input  logic [DATA_W-1:0] if_ins,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_pc4,
  output logic [DATA_W-1:0] id_ins,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [2*DATA_W-1:0] BEAT_RST = {{DATA_W{1'b0}}, NOP_INSTR};

  logic [2*DATA_W-1:0] out_beat;
  logic [DATA_W-1:0]   m_ins;
  logic                m_valid;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  pipe_skid_buf #(
    .W       (2 * DATA_W),
    .RST_VAL (BEAT_RST)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (flush),
    .in_tdata   ({if_pc4, if_ins}),
    .in_tvalid  (if_valid),
    .in_tready  (if_ready),
    .out_tdata  (out_beat),
    .out_tvalid (m_valid),
    .out_tready (id_ready)
  );

  assign {id_pc4, m_ins} = out_beat;
  assign id_valid        = m_valid;
  assign id_ins          = m_valid ? m_ins : NOP_INSTR;
  assign stall_cnt       = stall_cnt_q;

  // Debug counter survives flush; only reset clears it
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !id_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb/tb_if_id_pipe_reg.sv - scoreboard bench for if_id_pipe_reg
module tb_if_id_pipe_reg;

  localparam int          DW  = 32;
  localparam int          CW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int          CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_valid;
  logic          if_ready;
  logic [DW-1:0] if_pc4;
  logic [DW-1:0] if_ins;
  logic          flush;
  logic          id_valid;
  logic          id_ready;
  logic [DW-1:0] id_pc4;
  logic [DW-1:0] id_ins;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  if_id_pipe_reg #(
    .DATA_W    (DW),
    .NOP_INSTR (NOP),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_pc4    (if_pc4),
    .if_ins    (if_ins),
    .flush     (flush),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_pc4    (id_pc4),
    .id_ins    (id_ins),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] ins;
  } beat_t;

  int    errors = 0;
  int    checks = 0;
  beat_t sb_q[$];
  int    n_held = 0;
  int    exp_cnt = 0;
  bit    chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the register is a FIFO of depth two; count held beats and queue expected deliveries
  always @(posedge clk) begin
    bit cons;
    bit acc;
    if (!rst_n) begin
      sb_q.delete();
      n_held  = 0;
      exp_cnt = 0;
      chk_en  = 1'b1;
    end else if (chk_en) begin
      if (n_held > 0 && !id_ready && exp_cnt < CNT_MAX) exp_cnt++;
      cons = (n_held > 0) && id_ready;
      acc  = if_valid && (n_held < 2) && !flush;
      if (flush) begin
        n_held = 0;
        sb_q.delete();
      end else begin
        n_held = n_held - int'(cons) + int'(acc);
        if (acc) sb_q.push_back('{if_pc4, if_ins});
      end
    end
  end

  // Monitor: compare visible state and pop the scoreboard on each decode consume
  always @(negedge clk) begin
    beat_t b;
    if (chk_en) begin
      chk("id_valid", 64'(id_valid), 64'(n_held > 0));
      chk("if_ready", 64'(if_ready), 64'(n_held < 2));
      chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
      chk("skid_without_main", 64'(!id_valid && !if_ready), 64'(0));
      if (!id_valid) chk("id_ins_nop", 64'(id_ins), 64'(NOP));
      if (id_valid && id_ready && rst_n) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deliver_unexpected: got ins %0h expected none at %0t", id_ins, $time);
        end else begin
          b = sb_q.pop_front();
          chk("deliver_pc4", 64'(id_pc4), 64'(b.pc4));
          chk("deliver_ins", 64'(id_ins), 64'(b.ins));
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl, input logic rst);
    if_valid = v;
    if_pc4   = pc;
    if_ins   = ins;
    id_ready = rdy;
    flush    = fl;
    rst_n    = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    // reset then stream
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 32'h2001_0005, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'h8, 32'h2002_000A, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'hC, 32'h0022_1820, 1'b1, 1'b0, 1'b1);
    idle(3);

    // decode stall fill, third offer refused while full
    drive(1'b1, 32'h10, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h14, 32'h2222_2222, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h18, 32'h3333_3333, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // flush in FULL with a beat offered
    drive(1'b1, 32'h20, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h24, 32'hBBBB_BBBB, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h28, 32'hCCCC_CCCC, 1'b0, 1'b1, 1'b1);
    idle(2);

    // flush with a same-cycle consume: main delivered, skid squashed
    drive(1'b1, 32'h30, 32'hD0D0_D0D0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h34, 32'hE0E0_E0E0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    idle(2);

    // back-to-back consume and accept
    for (int i = 0; i < 8; i++)
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h5000_0000 + 32'(i), 1'b1, 1'b0, 1'b1);
    idle(2);

    // reset mid-stall
    drive(1'b1, 32'h40, 32'h6666_6666, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h44, 32'h7777_7777, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h48, 32'h8888_8888, 1'b0, 1'b1, 1'b0);
    idle(2);

    // counter saturation
    drive(1'b1, 32'h50, 32'h9999_9999, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 149) != 0);

    idle(4);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Pipeline register between the instruction-fetch stage and the instruction-decode stage.
- Captures the fetched instruction word and PC+4 each cycle and presents them to decode one cycle later.
- Uses a valid/ready handshake with a one-entry skid buffer, so a decode stall never drops an instruction already in flight from fetch.
- Supports a flush, used on taken branch/jump, that squashes all held instructions and emits a NOP bubble. Also keeps a saturating decode-stall cycle counter for debug.

Parameters:
- DATA_W, 32, width of instruction word and PC fields
- NOP_INSTR, 32'h0000_0000, instruction word driven on id_ins when id_valid=0 or after flush/reset
- CNT_W, 16, width of stall_cnt

Ports:
- clk  input  1  single system clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- if_valid  input  1  fetch presents a valid instruction this cycle
- if_ready  output  1  register can accept the fetch beat this cycle
- if_pc4  input  DATA_W  PC+4 of the fetched instruction
- if_ins  input  DATA_W  fetched instruction word
- flush  input  1  squash all held and incoming instructions this cycle
- id_valid  output  1  id_pc4/id_ins hold a valid instruction
- id_ready  input  1  decode accepts the presented instruction this cycle
- id_pc4  output  DATA_W  PC+4 presented to decode
- id_ins  output  DATA_W  instruction presented to decode
- stall_cnt  output  CNT_W  count of cycles with id_valid=1 and id_ready=0, saturating

Behaviour:
- Storage:
  - main register (m_valid, m_pc4, m_ins) drives the id_* outputs directly.
  - skid register (s_valid, s_pc4, s_ins) holds at most one overflow beat.
- Handshake:
  - if_ready = !s_valid, a registered-state function with no combinational path from id_ready.
  - Fetch beat accepted when if_valid && if_ready.
  - Decode beat consumed when id_valid && id_ready.
- Outputs:
  - id_valid = m_valid.
  - id_pc4 = m_pc4.
  - id_ins = m_ins when m_valid, else NOP_INSTR.
- Latency: an accepted beat appears on id_* on the next cycle when the main register is empty or being consumed. Throughput is 1 instruction/cycle when id_ready stays high.
- States per cycle, (m_valid, s_valid):
  - EMPTY (0,0): accept → main. Next state BUSY or EMPTY.
  - BUSY (1,0):
    - consume with no accept → EMPTY.
    - consume with accept → main reloaded, BUSY.
    - no consume with accept → beat goes to skid, FULL.
    - no consume, no accept → BUSY.
  - FULL (1,1): if_ready=0, so no accept.
    - consume → skid moves to main, skid cleared, BUSY.
    - no consume → hold.
  - (0,1) is unreachable. The bench asserts it never occurs.
- Ordering: beats are delivered to decode strictly in acceptance order, with no loss and no duplication.
- Flush, highest priority below reset:
  - Next state EMPTY: m_valid=0, s_valid=0, m_ins=NOP_INSTR.
  - A beat offered on if_* in the flush cycle is discarded even if if_ready=1.
  - A decode consume in the same cycle still counts as delivered.
- Reset, when rst_n=0 at a rising edge:
  - m_valid=0, s_valid=0.
  - m_pc4=0, s_pc4=0.
  - m_ins=NOP_INSTR, s_ins=NOP_INSTR.
  - stall_cnt=0.
  - Outputs after reset: id_valid=0, if_ready=1, id_ins=NOP_INSTR.
  - Reset mid-stall drops all held beats.
  - Reset overrides flush.
- stall_cnt:
  - Increments by 1 each cycle with id_valid && !id_ready.
  - Saturates at 2^CNT_W-1.
  - Not cleared by flush.
- Data registers load only on their accept/move conditions, so stale data is held otherwise.

Decomposition:
- Shared pipeline package holds DATA_W and the NOP_INSTR constant, the encoding of sll $0,$0,0.
- One natural sub-module: pipe_skid_buf, a generic valid/ready main+skid register parameterised on payload width.
  - This block instantiates it with a 2*DATA_W payload {pc4, ins}.
  - The top level adds the NOP substitution, flush and stall_cnt.
- The ID/EX and EX/MEM registers reuse pipe_skid_buf.

Test Plan:
- Reset then stream: rst_n=0 for 2 cycles, then if_valid=1 with ins 0x2001_0005, 0x2002_000A, 0x0022_1820, pc4 0x4/0x8/0xC, and id_ready=1 → same triplets on id_* on cycles 1-3 after acceptance, id_valid high 3 cycles, stall_cnt=0.
- Decode stall fill: id_ready=0 while sending 0x1111_1111 then 0x2222_2222 → id_ins holds 0x1111_1111, if_ready drops to 0 after the second accept, stall_cnt increments every cycle. Raise id_ready → 0x1111_1111 then 0x2222_2222 delivered, if_ready returns to 1.
- Flush in FULL state: main=0xAAAA_AAAA, skid=0xBBBB_BBBB, flush=1 with if_ins=0xCCCC_CCCC → next cycle id_valid=0, id_ins=0x0000_0000, if_ready=1. None of the three words is ever delivered.
- Simultaneous consume and accept in BUSY: id_ready=1 and if_valid=1 each cycle for 8 cycles → s_valid never set, 8 distinct words delivered in order, back-to-back.
- Reset mid-operation: FULL state then rst_n=0 for 1 cycle → id_valid=0, if_ready=1, stall_cnt=0, id_ins=NOP_INSTR.
- Counter saturation with CNT_W=4: hold id_valid=1, id_ready=0 for 20 cycles → stall_cnt reaches 15 and stays at 15.
